// File: rtl/wb_stage.sv
// wb_stage: MEM/WB pipeline register, writeback mux with load extension, and retired-instruction counter
// Ports: clk/rst (sync active-high); en (0 = stall); flush (bubble next edge);
//   in_* : instruction leaving MEM (valid, rd source select, load controls, pc, imm, alu, rdata);
//   rf_we/rf_waddr/rf_wdata : register-file write port; wb_valid : registered valid; instret : 64-bit retire count.
module wb_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            flush,
  input  logic            in_valid,
  input  logic [1:0]      in_rd_sel,
  input  logic            in_mem_to_reg,
  input  logic            in_reg_write,
  input  logic [4:0]      in_rd_addr,
  input  logic            in_compressed,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_imm,
  input  logic [XLEN-1:0] in_alu_result,
  input  logic [XLEN-1:0] in_mem_rdata,
  input  logic [2:0]      in_funct3,
  input  logic [1:0]      in_addr_lo,
  output logic            rf_we,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic            wb_valid,
  output logic [63:0]     instret
);
  logic            r_valid;
  logic [1:0]      r_rd_sel;
  logic            r_mem_to_reg;
  logic            r_reg_write;
  logic [4:0]      r_rd;
  logic            r_compressed;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_imm;
  logic [XLEN-1:0] r_alu;
  logic [XLEN-1:0] r_rdata;
  logic [2:0]      r_funct3;
  logic [1:0]      r_addr_lo;
  logic [63:0]     r_instret;
  // Set by reset until the first capture: zeroed fields would otherwise select link data (pc+4).
  logic            r_zero;
  logic [XLEN-1:0] w_shift;
  logic [7:0]      w_byte;
  logic [15:0]     w_half;
  logic [XLEN-1:0] w_load;
  logic [XLEN-1:0] w_link;
  logic [XLEN-1:0] w_mux;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid      <= 1'b0;
      r_rd_sel     <= '0;
      r_mem_to_reg <= 1'b0;
      r_reg_write  <= 1'b0;
      r_rd         <= '0;
      r_compressed <= 1'b0;
      r_pc         <= '0;
      r_imm        <= '0;
      r_alu        <= '0;
      r_rdata      <= '0;
      r_funct3     <= '0;
      r_addr_lo    <= '0;
      r_instret    <= '0;
      r_zero       <= 1'b1;
    end else begin
      if (flush) begin
        r_valid <= 1'b0;
      end else if (en) begin
        r_valid      <= in_valid;
        r_rd_sel     <= in_rd_sel;
        r_mem_to_reg <= in_mem_to_reg;
        r_reg_write  <= in_reg_write;
        r_rd         <= in_rd_addr;
        r_compressed <= in_compressed;
        r_pc         <= in_pc;
        r_imm        <= in_imm;
        r_alu        <= in_alu_result;
        r_rdata      <= in_mem_rdata;
        r_funct3     <= in_funct3;
        r_addr_lo    <= in_addr_lo;
        r_zero       <= 1'b0;
      end
      // Counted on the edge that moves the instruction out, so a stall counts it once.
      if (r_valid && en) r_instret <= r_instret + 64'd1;
    end
  end
  always_comb begin
    w_shift = r_rdata >> {r_addr_lo, 3'b000};
    w_byte  = w_shift[7:0];
    w_half  = r_addr_lo[1] ? r_rdata[31:16] : r_rdata[15:0];
    w_load  = (r_funct3 == 3'b000) ? {{24{w_byte[7]}}, w_byte} :
              (r_funct3 == 3'b001) ? {{16{w_half[15]}}, w_half} :
              (r_funct3 == 3'b100) ? {24'd0, w_byte} :
              (r_funct3 == 3'b101) ? {16'd0, w_half} : r_rdata;
    w_link  = r_pc + (r_compressed ? 32'd2 : 32'd4);
    w_mux   = (r_rd_sel == 2'b00) ? w_link :
              (r_rd_sel == 2'b01) ? r_pc + r_imm :
              (r_rd_sel == 2'b10) ? r_imm :
              (r_mem_to_reg ? w_load : r_alu);
  end
  assign rf_we    = r_valid & r_reg_write & (r_rd != 5'd0);
  assign rf_waddr = r_rd;
  assign rf_wdata = (rst | r_zero) ? '0 : w_mux;
  assign wb_valid = r_valid;
  assign instret  = r_instret;
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed self-checking bench for wb_stage
module tb_wb_stage;
  logic        clk = 1'b0;
  logic        rst, en, flush, in_valid, in_mem_to_reg, in_reg_write, in_compressed;
  logic [1:0]  in_rd_sel, in_addr_lo;
  logic [4:0]  in_rd_addr;
  logic [2:0]  in_funct3;
  logic [31:0] in_pc, in_imm, in_alu_result, in_mem_rdata;
  logic        rf_we, wb_valid;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [63:0] instret;
  int          n_checks = 0;
  int          n_errors = 0;
  logic        m_valid = 1'b0;
  logic [63:0] exp_ir = 64'd0;

  wb_stage dut (
    .clk(clk), .rst(rst), .en(en), .flush(flush), .in_valid(in_valid),
    .in_rd_sel(in_rd_sel), .in_mem_to_reg(in_mem_to_reg), .in_reg_write(in_reg_write),
    .in_rd_addr(in_rd_addr), .in_compressed(in_compressed), .in_pc(in_pc), .in_imm(in_imm),
    .in_alu_result(in_alu_result), .in_mem_rdata(in_mem_rdata), .in_funct3(in_funct3),
    .in_addr_lo(in_addr_lo), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .wb_valid(wb_valid), .instret(instret)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Retire-count model: one count per edge that releases a valid instruction.
  task automatic step();
    if (rst) begin
      exp_ir  = 64'd0;
      m_valid = 1'b0;
    end else begin
      if (m_valid && en) exp_ir++;
      m_valid = flush ? 1'b0 : en ? in_valid : m_valid;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] sel, input logic m2r, input logic rw,
                       input logic [4:0] rd, input logic comp, input logic [31:0] pc,
                       input logic [31:0] imm, input logic [31:0] alu, input logic [31:0] rdata,
                       input logic [2:0] f3, input logic [1:0] alo);
    in_valid = v; in_rd_sel = sel; in_mem_to_reg = m2r; in_reg_write = rw; in_rd_addr = rd;
    in_compressed = comp; in_pc = pc; in_imm = imm; in_alu_result = alu; in_mem_rdata = rdata;
    in_funct3 = f3; in_addr_lo = alo;
  endtask

  task automatic load(input string tag, input logic [2:0] f3, input logic [1:0] alo,
                      input logic [31:0] exp);
    drive(1, 2'b11, 1, 1, 5'd9, 0, 32'h0, 32'h0, 32'hDEADBEEF, 32'h80FF7F01, f3, alo);
    step();
    check(tag, {32'd0, rf_wdata}, {32'd0, exp});
    check({tag, "_ir"}, instret, exp_ir);
  endtask

  initial begin
    rst = 1; en = 1; flush = 0;
    drive(0, 2'b00, 0, 0, 5'd0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 3'b000, 2'b00);
    step();
    rst = 0; en = 0;
    #1;
    check("rst_we", {63'd0, rf_we}, 64'd0);
    check("rst_waddr", {59'd0, rf_waddr}, 64'd0);
    check("rst_wdata", {32'd0, rf_wdata}, 64'd0);
    check("rst_valid", {63'd0, wb_valid}, 64'd0);
    check("rst_ir", instret, 64'd0);
    en = 1;
    drive(1, 2'b00, 0, 1, 5'd1, 0, 32'h100, 32'h0, 32'h0, 32'h0, 3'b000, 2'b00);
    step();
    check("jal_wdata", {32'd0, rf_wdata}, 64'h104);
    check("jal_we", {63'd0, rf_we}, 64'd1);
    check("jal_waddr", {59'd0, rf_waddr}, 64'd1);
    check("jal_ir", instret, 64'd0);
    drive(1, 2'b00, 0, 1, 5'd1, 1, 32'h100, 32'h0, 32'h0, 32'h0, 3'b000, 2'b00);
    step();
    check("cjal_wdata", {32'd0, rf_wdata}, 64'h102);
    check("cjal_ir", instret, 64'd1);
    drive(1, 2'b01, 0, 1, 5'd2, 0, 32'hFFFFFFF0, 32'h20, 32'h0, 32'h0, 3'b000, 2'b00);
    step();
    check("auipc_wrap", {32'd0, rf_wdata}, 64'h10);
    drive(1, 2'b10, 0, 1, 5'd3, 0, 32'h1000, 32'hABCDE000, 32'h0, 32'h0, 3'b000, 2'b00);
    step();
    check("lui", {32'd0, rf_wdata}, 64'hABCDE000);
    check("lui_ir", instret, 64'd3);
    load("lb3", 3'b000, 2'd3, 32'hFFFFFF80);
    load("lbu1", 3'b100, 2'd1, 32'h0000007F);
    load("lh2", 3'b001, 2'd2, 32'hFFFF80FF);
    load("lh3", 3'b001, 2'd3, 32'hFFFF80FF);
    load("lhu0", 3'b101, 2'd0, 32'h00007F01);
    load("lw", 3'b010, 2'd1, 32'h80FF7F01);
    load("f3_011", 3'b011, 2'd0, 32'h80FF7F01);
    drive(1, 2'b11, 0, 1, 5'd4, 0, 32'h0, 32'h0, 32'h12345678, 32'h80FF7F01, 3'b000, 2'b00);
    step();
    check("alu", {32'd0, rf_wdata}, 64'h12345678);
    drive(1, 2'b10, 0, 1, 5'd0, 0, 32'h0, 32'h77, 32'h0, 32'h0, 3'b000, 2'b00);
    step();
    check("x0_we", {63'd0, rf_we}, 64'd0);
    check("x0_valid", {63'd0, wb_valid}, 64'd1);
    drive(1, 2'b10, 0, 1, 5'd7, 0, 32'h0, 32'h55, 32'h0, 32'h0, 3'b000, 2'b00);
    step();
    check("x0_counted", instret, 64'd13);
    en = 0;
    for (int i = 0; i < 3; i++) begin
      drive(1, 2'b10, 0, 1, 5'd8, 0, 32'h0, 32'h99, 32'h0, 32'h0, 3'b000, 2'b00);
      step();
      check("stall_wdata", {32'd0, rf_wdata}, 64'h55);
      check("stall_we", {63'd0, rf_we}, 64'd1);
      check("stall_waddr", {59'd0, rf_waddr}, 64'd7);
      check("stall_ir", instret, 64'd13);
    end
    en = 1;
    drive(0, 2'b10, 0, 1, 5'd8, 0, 32'h0, 32'h99, 32'h0, 32'h0, 3'b000, 2'b00);
    step();
    check("release_ir", instret, 64'd14);
    check("release_valid", {63'd0, wb_valid}, 64'd0);
    drive(1, 2'b10, 0, 1, 5'd5, 0, 32'h0, 32'h66, 32'h0, 32'h0, 3'b000, 2'b00);
    step();
    en = 0;
    step();
    flush = 1;
    step();
    check("flush_valid", {63'd0, wb_valid}, 64'd0);
    check("flush_we", {63'd0, rf_we}, 64'd0);
    flush = 0; en = 1;
    drive(0, 2'b10, 0, 1, 5'd5, 0, 32'h0, 32'h66, 32'h0, 32'h0, 3'b000, 2'b00);
    step();
    check("flush_ir", instret, 64'd14);
    rst = 1;
    step();
    rst = 0;
    for (int i = 0; i < 6; i++) begin
      drive(1, 2'b10, 0, 1, 5'(i + 10), 0, 32'h0, 32'(i), 32'h0, 32'h0, 3'b000, 2'b00);
      step();
    end
    check("five_ir", instret, 64'd5);
    en = 0;
    step();
    check("hold_ir", instret, 64'd5);
    rst = 1;
    step();
    rst = 0;
    #1;
    check("mrst_we", {63'd0, rf_we}, 64'd0);
    check("mrst_waddr", {59'd0, rf_waddr}, 64'd0);
    check("mrst_wdata", {32'd0, rf_wdata}, 64'd0);
    check("mrst_valid", {63'd0, wb_valid}, 64'd0);
    check("mrst_ir", instret, 64'd0);
    en = 1;
    drive(1, 2'b10, 0, 1, 5'd6, 0, 32'h0, 32'h1, 32'h0, 32'h0, 3'b000, 2'b00);
    step();
    check("restart0_ir", instret, 64'd0);
    drive(0, 2'b10, 0, 1, 5'd6, 0, 32'h0, 32'h1, 32'h0, 32'h0, 3'b000, 2'b00);
    step();
    check("restart1_ir", instret, 64'd1);
    check("model_ir", instret, exp_ir);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/wb_stage.md
# wb_stage

MEM/WB pipeline register and writeback unit for the RV32IC core. It captures the instruction leaving the memory stage and applies the 2-bit rd-source select produced by decode (link, AUIPC, LUI or datapath result). It sign/zero-extends load data and drives the register-file write port. It also keeps a 64-bit retired-instruction counter.

## Interface
Parameters:
- `XLEN`, 32, datapath width; only 32 is supported.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  stage enable; 0 = stall (hold all registered state).
- `flush`  in  1  load a bubble on the next edge.
- `in_valid`  in  1  MEM stage holds a real instruction.
- `in_rd_sel`  in  2  rd source: 00 link, 01 AUIPC (pc+imm), 10 LUI (imm), 11 datapath result.
- `in_mem_to_reg`  in  1  with sel 11: 1 = load data, 0 = ALU result.
- `in_reg_write`  in  1  instruction writes rd.
- `in_rd_addr`  in  5  destination register.
- `in_compressed`  in  1  16-bit instruction; link is pc+2 instead of pc+4.
- `in_pc`  in  32  instruction address.
- `in_imm`  in  32  decoded immediate (U-type already shifted).
- `in_alu_result`  in  32  ALU output.
- `in_mem_rdata`  in  32  raw aligned memory word.
- `in_funct3`  in  3  load width/sign.
- `in_addr_lo`  in  2  load address bits [1:0].
- `rf_we`  out  1  register-file write enable.
- `rf_waddr`  out  5  register-file write address.
- `rf_wdata`  out  32  register-file write data.
- `wb_valid`  out  1  registered instruction valid, for the hazard/forwarding unit.
- `instret`  out  64  count of retired instructions.

## Operation
Registered fields: every `in_*` signal except `in_valid` is captured into a `*_q` copy; `valid_q` is derived as follows.
- `rst`: clear every field to 0, including `valid_q` and `instret`.
- `flush`: set `valid_q` to 0, regardless of `en`. Other fields are don't-care.
- `en=1`, no flush: capture all inputs; `valid_q <= in_valid`.
- `en=0`, no flush: hold everything.

Writeback mux (combinational from the registered fields):
- 00: `pc_q + (compressed_q ? 2 : 4)`, modulo 2^32.
- 01: `pc_q + imm_q`, modulo 2^32.
- 10: `imm_q`.
- 11 with mem_to_reg=0: `alu_q`.
- 11 with mem_to_reg=1: load-extended data.

Load extension:
- Byte lane = `rdata[8*addr_lo+7 : 8*addr_lo]`.
- Half lane = `addr_lo[1] ? rdata[31:16] : rdata[15:0]`; `addr_lo[0]` is ignored.
- funct3 000 LB: sign-extend byte.
- 001 LH: sign-extend half.
- 010 LW: full word.
- 100 LBU: zero-extend byte.
- 101 LHU: zero-extend half.
- Any other funct3 value: treated as LW.

Outputs:
- `rf_we = valid_q & reg_write_q & (rd_q != 0)`. Writes to x0 are never issued.
- `rf_waddr = rd_q`. `rf_wdata` = mux output. Both are driven even when `rf_we=0`.
- `wb_valid = valid_q`.

`instret`:
- Increments by 1 on each edge where `valid_q & en & ~rst`.
- Wraps 2^64-1 to 0.
- A stalled instruction is counted once, on the edge that releases it.

## Timing
- Latency: inputs presented with `en=1` at edge N appear on `rf_*` in the cycle after edge N. The register file writes them at edge N+1.
- During a stall, `rf_we` and `rf_wdata` stay asserted and unchanged; repeated writes of the same value are idempotent.
- Simultaneous `flush` and `en=0`: flush wins, and the held instruction is discarded uncounted.
- Simultaneous `rst` and `flush`/`en`: reset wins.
- Reset mid-stall: all outputs read 0 the cycle after the reset edge. Reset values: `rf_we=0`, `rf_waddr=0`, `rf_wdata=0` (pc 0, sel 00 still selects link, so the data path must force 0 while reset is applied), `wb_valid=0`, `instret=0`.

## Test plan
- **JAL/compressed link:** pc=0x100, sel=00, rd=1. compressed=0 → `rf_wdata=0x104`, `rf_we=1`. compressed=1 → `0x102`.
- **AUIPC/LUI:** pc=0xFFFFFFF0, imm=0x00000020, sel=01 → `0x00000010` (wrap). sel=10, imm=0xABCDE000 → `0xABCDE000`.
- **Loads:** rdata=0x80FF7F01.
  - LB addr_lo=3 → 0xFFFFFF80.
  - LBU addr_lo=1 → 0x0000007F.
  - LH addr_lo=2 → 0xFFFF80FF.
  - LHU addr_lo=0 → 0x00007F01.
  - LW → 0x80FF7F01.
- **x0 suppression:** reg_write=1, rd=0, valid=1 → `rf_we=0`. `instret` still increments.
- **Stall/flush:** valid instruction, then `en=0` for 3 cycles → outputs held and `instret` +1 only on release. Assert `flush` during a stall → `wb_valid=0` next cycle and no count.
- **Reset:** run 5 valid instructions (`instret=5`), then assert `rst` for 1 cycle mid-stall → all outputs 0 after the edge, and counting restarts from 0.
